// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the boot-time system ID check master.
// Used by sysid_check_timer and sysid_check_master.
package sysid_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID_REQ,
    RD_ID_WAIT,
    RD_TS_REQ,
    RD_TS_WAIT,
    CHECK,
    DONE
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  function automatic int timer_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sysid_check_timer.sv
// Per-read-phase cycle timer: cleared between phases, counts while enabled,
// flags the last allowed cycle of a read transaction.
module sysid_check_timer
  import sysid_check_pkg::*;
#(
  parameter int CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = timer_width(CYCLES);

  logic [W-1:0] count;

  // count holds the index of the current cycle within the phase (0-based)
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(CYCLES - 1));

endmodule

// File: rtl/sysid_check_master.sv
// Avalon-MM read master that checks the system ID slave (ID, then timestamp).
// Optional macro SYSID_CHECK_AUTOSTART_EN: run one check automatically after reset.
module sysid_check_master
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h2013_0731,
  parameter logic [31:0] EXP_TS         = 32'h525C_44FB,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          RETRY_MAX      = 3
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         id_mismatch,
  output logic         ts_mismatch,
  output logic         timeout,
  output logic [31:0]  id_value,
  output logic [31:0]  ts_value,
  output logic         m_address,
  output logic         m_read,
  input  logic         m_waitrequest,
  input  logic [31:0]  m_readdata,
  input  logic         m_readdatavalid,
  output sysid_state_e dbg_state
);

  localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  // Handshake: a command is accepted in any cycle with m_read=1 and
  // m_waitrequest=0; m_read/m_address hold until then. readdatavalid is only
  // honoured in a REQ acceptance cycle or a WAIT state, so stale data is dropped.

  sysid_state_e  state;
  logic [RW-1:0] retry_cnt;
  logic          start_int;
  logic          in_req;
  logic          in_wait;
  logic          in_xfer;
  logic          read_done;
  logic          tmr_expired;
  logic          tmr_clear;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_pend;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      auto_pend <= 1'b1;
    end else begin
      auto_pend <= 1'b0;
    end
  end

  assign start_int = start | auto_pend;
`else
  assign start_int = start;
`endif

  assign in_req    = (state == RD_ID_REQ) || (state == RD_TS_REQ);
  assign in_wait   = (state == RD_ID_WAIT) || (state == RD_TS_WAIT);
  assign in_xfer   = in_req || in_wait;
  assign read_done = (in_req && !m_waitrequest && m_readdatavalid) ||
                     (in_wait && m_readdatavalid);
  assign tmr_clear = !in_xfer || read_done || tmr_expired;
  assign dbg_state = state;

  sysid_check_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (in_xfer),
    .expired (tmr_expired)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      m_read      <= 1'b0;
      m_address   <= SYSID_ADDR_ID;
      id_value    <= '0;
      ts_value    <= '0;
      retry_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (in_xfer && !read_done && tmr_expired) begin
        // Read phase ran out of cycles: restart the whole sequence or give up
        if (int'(retry_cnt) < RETRY_MAX) begin
          retry_cnt <= retry_cnt + RW'(1);
          state     <= RD_ID_REQ;
          m_read    <= 1'b1;
          m_address <= SYSID_ADDR_ID;
        end else begin
          timeout   <= 1'b1;
          pass      <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          m_read    <= 1'b0;
          m_address <= SYSID_ADDR_ID;
          state     <= DONE;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start_int) begin
              state       <= RD_ID_REQ;
              busy        <= 1'b1;
              pass        <= 1'b0;
              id_mismatch <= 1'b0;
              ts_mismatch <= 1'b0;
              timeout     <= 1'b0;
              retry_cnt   <= '0;
              m_read      <= 1'b1;
              m_address   <= SYSID_ADDR_ID;
            end
          end
          RD_ID_REQ: begin
            if (!m_waitrequest) begin
              if (m_readdatavalid) begin
                id_value  <= m_readdata;
                m_address <= SYSID_ADDR_TS;
                state     <= RD_TS_REQ;
              end else begin
                m_read <= 1'b0;
                state  <= RD_ID_WAIT;
              end
            end
          end
          RD_ID_WAIT: begin
            if (m_readdatavalid) begin
              id_value  <= m_readdata;
              m_read    <= 1'b1;
              m_address <= SYSID_ADDR_TS;
              state     <= RD_TS_REQ;
            end
          end
          RD_TS_REQ: begin
            if (!m_waitrequest) begin
              m_read <= 1'b0;
              if (m_readdatavalid) begin
                ts_value <= m_readdata;
                state    <= CHECK;
              end else begin
                state <= RD_TS_WAIT;
              end
            end
          end
          RD_TS_WAIT: begin
            if (m_readdatavalid) begin
              ts_value <= m_readdata;
              state    <= CHECK;
            end
          end
          CHECK: begin
            id_mismatch <= (id_value != EXP_ID);
            ts_mismatch <= (ts_value != EXP_TS);
            pass        <= (id_value == EXP_ID) && (ts_value == EXP_TS);
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sysid_check_master.sv
// Directed bench for sysid_check_master with a reactive Avalon-MM slave model.
// Honours SYSID_CHECK_AUTOSTART_EN when the build defines it.
module tb_sysid_check_master;
  import sysid_check_pkg::*;

  localparam logic [31:0] EXP_ID  = 32'h2013_0731;
  localparam logic [31:0] EXP_TS  = 32'h525C_44FB;
  localparam int          TMO     = 10;
  localparam int          RETRIES = 2;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic         busy;
  logic         done;
  logic         pass;
  logic         id_mismatch;
  logic         ts_mismatch;
  logic         timeout;
  logic [31:0]  id_value;
  logic [31:0]  ts_value;
  logic         m_address;
  logic         m_read;
  logic         m_waitrequest;
  logic [31:0]  m_readdata;
  logic         m_readdatavalid;
  sysid_state_e dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // slave model configuration and bookkeeping
  int          cfg_wait = 0;
  int          cfg_lat  = 0;
  logic        cfg_dead = 1'b0;
  logic [31:0] cfg_id   = EXP_ID;
  logic [31:0] cfg_ts   = EXP_TS;
  int          stall_cnt = 0;
  int          stall_err = 0;
  logic        stall_addr = 1'b0;
  int          id_acc   = 0;
  int          done_cnt = 0;
  logic        pend_valid = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;

  sysid_check_master #(
    .EXP_ID         (EXP_ID),
    .EXP_TS         (EXP_TS),
    .TIMEOUT_CYCLES (TMO),
    .RETRY_MAX      (RETRIES)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_mismatch     (id_mismatch),
    .ts_mismatch     (ts_mismatch),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .dbg_state       (dbg_state)
  );

  // clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // slave model: reacts on the falling edge to what the master drove
  initial begin
    m_waitrequest   = 1'b0;
    m_readdata      = '0;
    m_readdatavalid = 1'b0;
    forever begin
      @(negedge clock);
      if (done) done_cnt++;
      m_readdatavalid = 1'b0;
      if (pend_valid) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          m_readdatavalid = 1'b1;
          m_readdata      = pend_data;
          pend_valid      = 1'b0;
        end
      end
      if (m_read) begin
        if (stall_cnt > 0 && m_address != stall_addr) stall_err++;
        stall_addr = m_address;
        if (stall_cnt < cfg_wait) begin
          m_waitrequest = 1'b1;
          stall_cnt++;
        end else begin
          m_waitrequest = 1'b0;
          stall_cnt = 0;
          if (m_address == SYSID_ADDR_ID) id_acc++;
          if (!cfg_dead) begin
            if (cfg_lat == 0) begin
              m_readdatavalid = 1'b1;
              m_readdata      = m_address ? cfg_ts : cfg_id;
            end else begin
              pend_valid = 1'b1;
              pend_cnt   = cfg_lat;
              pend_data  = m_address ? cfg_ts : cfg_id;
            end
          end
        end
      end else begin
        if (stall_cnt > 0) stall_err++;
        m_waitrequest = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    start   = 1'b0;
    repeat (n) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // returns the cycle index (start cycle = 0) at which done is seen
  task automatic wait_done(input int max_cycles, output int lat);
    lat = 1;
    while (!done && lat < max_cycles) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] id_d, input logic [31:0] ts_d,
                          input int w, input int l, input int exp_lat,
                          input logic exp_pass, input logic exp_idm, input logic exp_tsm);
    int lat;
    cfg_id    = id_d;
    cfg_ts    = ts_d;
    cfg_wait  = w;
    cfg_lat   = l;
    cfg_dead  = 1'b0;
    stall_err = 0;
    exp_q.push_back(id_d);
    exp_q.push_back(ts_d);
    pulse_start();
    check({tag, ":busy"}, busy, 1'b1);
    wait_done(200, lat);
    check({tag, ":latency"}, lat, exp_lat);
    check({tag, ":pass"}, pass, exp_pass);
    check({tag, ":id_mismatch"}, id_mismatch, exp_idm);
    check({tag, ":ts_mismatch"}, ts_mismatch, exp_tsm);
    check({tag, ":timeout"}, timeout, 1'b0);
    check({tag, ":busy_done"}, busy, 1'b0);
    check({tag, ":id_value"}, id_value, exp_q.pop_front());
    check({tag, ":ts_value"}, ts_value, exp_q.pop_front());
    check({tag, ":stall_stable"}, stall_err, 0);
  endtask

  initial begin
    int lat;
    int done_snap;
    int found;
    do_reset(3);
    check("rst:state", 32'(dbg_state), 32'(IDLE));
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:pass", pass, 1'b0);
    check("rst:timeout", timeout, 1'b0);
    check("rst:m_read", m_read, 1'b0);
    check("rst:m_address", m_address, 1'b0);
    check("rst:id_value", id_value, 32'h0);
    check("rst:ts_value", ts_value, 32'h0);
`ifdef SYSID_CHECK_AUTOSTART_EN
    @(negedge clock);
    check("auto:busy", busy, 1'b1);
    wait_done(100, lat);
    check("auto:latency", lat, 4);
    check("auto:pass", pass, 1'b1);
    check("auto:id_value", id_value, EXP_ID);
`else
    repeat (4) @(negedge clock);
    check("idle:busy", busy, 1'b0);
    check("idle:state", 32'(dbg_state), 32'(IDLE));

    // matching slave, zero wait, zero latency
    run_case("match", EXP_ID, EXP_TS, 0, 0, 4, 1'b1, 1'b0, 1'b0);
    // start during DONE is ignored
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("done_start:state", 32'(dbg_state), 32'(IDLE));
    check("done_start:busy", busy, 1'b0);
    repeat (2) @(negedge clock);
    check("done_start:state2", 32'(dbg_state), 32'(IDLE));
    check("hold:pass", pass, 1'b1);

    run_case("ts_bad", EXP_ID, 32'h0000_0001, 0, 0, 4, 1'b0, 1'b0, 1'b1);
    run_case("id_bad", 32'hDEAD_BEEF, EXP_TS, 0, 0, 4, 1'b0, 1'b1, 1'b0);
    run_case("stall", EXP_ID, EXP_TS, 5, 2, 18, 1'b1, 1'b0, 1'b0);
    run_case("lat3", EXP_ID, EXP_TS, 0, 3, 10, 1'b1, 1'b0, 1'b0);
    run_case("wait2", EXP_ID, EXP_TS, 2, 0, 8, 1'b1, 1'b0, 1'b0);

    // dead slave: three attempts of TMO cycles, then give up
    cfg_dead  = 1'b1;
    cfg_wait  = 0;
    id_acc    = 0;
    done_snap = done_cnt;
    pulse_start();
    wait_done(200, lat);
    check("dead:latency", lat, 31);
    check("dead:timeout", timeout, 1'b1);
    check("dead:pass", pass, 1'b0);
    check("dead:attempts", id_acc, 3);
    repeat (3) @(negedge clock);
    check("dead:done_once", done_cnt - done_snap, 1);
    check("dead:m_read", m_read, 1'b0);
    check("dead:busy", busy, 1'b0);
    cfg_dead = 1'b0;

    // reset while waiting for the timestamp, then a late response arrives
    cfg_id   = EXP_ID;
    cfg_ts   = EXP_TS;
    cfg_wait = 0;
    cfg_lat  = 6;
    pulse_start();
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      if (dbg_state == RD_TS_WAIT) found = 1;
      else @(negedge clock);
    end
    check("mid:reached_ts_wait", found, 1);
    reset_n = 1'b0;
    @(negedge clock);
    check("mid:m_read", m_read, 1'b0);
    check("mid:busy", busy, 1'b0);
    check("mid:state", 32'(dbg_state), 32'(IDLE));
    check("mid:id_value", id_value, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    check("late:ts_value", ts_value, 32'h0);
    check("late:id_value", id_value, 32'h0);
    check("late:state", 32'(dbg_state), 32'(IDLE));
    check("late:pass", pass, 1'b0);
    check("late:pending_gone", pend_valid, 1'b0);
    run_case("after_rst", EXP_ID, EXP_TS, 0, 0, 4, 1'b1, 1'b0, 1'b0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
